seg_scan_receiver: RTL
======================

Name: seg_scan_receiver

Overview:
- Receive-side counterpart of the team's 3-bit-code → 8-bit segment-pattern decoder.
- Samples a multiplexed display bus (segment pattern plus one-hot digit enable) and recovers the 3-bit code shown on each of 8 digit positions.
- Presents a complete 8-digit frame over a valid/ready handshake.
- Used in self-check and loopback paths between the segment driver and the display pins.

Parameters:
- STABLE_CYCLES, 3: consecutive cycles seg_in/den_in must hold unchanged before capture (legal range 1..15).
- CNT_W, 4: stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-low
- seg_in  input  8  segment pattern
- den_in  input  8  digit enable; one-hot selects the digit, all-zero = inter-digit gap
- fr_data  output  24  captured frame; digit i code at [3i+2:3i]
- fr_blank  output  8  per-digit flag: pattern was 8'h00
- fr_valid  output  1  frame available
- fr_ready  input  1  consumer accepts frame
- err_pulse  output  1  one-cycle flag: illegal stable sample
- err_cnt  output  8  saturating error count (see Optional Feature)

Behaviour:
- Pattern table (code→pattern):
  - 000→F8, 001→30, 010→92, 011→79
  - 100→02, 101→A4, 110→99, 111→C0
  - 00 = blank
- Reset (reset==0 at posedge):
  - FSM → IDLE; counter = 0.
  - Shadow codes, shadow_valid[7:0], fr_data, fr_blank, fr_valid, err_pulse, err_cnt all = 0.
  - Applies mid-frame and mid-handshake; a pending frame is discarded.
- Input regs: seg_in/den_in registered once (prev_seg/prev_den) for change detection.
- FSM states:
  - IDLE: den_in==0 → stay, counter=0. Otherwise → SETTLE, counter=1.
  - SETTLE: inputs equal prev → counter+1. Change → counter=1, stay. den_in==0 → IDLE. counter reaches STABLE_CYCLES → evaluate sample that cycle, go CAPTURED.
  - CAPTURED: hold until inputs change. den_in==0 → IDLE. Other change → SETTLE, counter=1.
- Capture latency: first cycle of new value + STABLE_CYCLES−1 further cycles; evaluated on the STABLE_CYCLES-th consecutive equal cycle.
- Evaluation rules:
  - Illegal sample: den_in not one-hot, or seg_in not in the table and not 00. Action: err_pulse=1 for exactly one cycle, no shadow update.
  - Legal sample, digit i = index of the den_in bit: shadow code[i] = decoded code; blank[i] = (seg_in==00), with code 000 when blank; shadow_valid[i]=1.
  - Recapturing the same digit overwrites it.
- Frame transfer:
  - Condition: shadow_valid==8'hFF and (!fr_valid or fr_ready).
  - Action: copy shadow → fr_data/fr_blank, fr_valid=1, shadow_valid=0.
  - An evaluation in the same cycle lands in the new (cleared) shadow.
- Handshake:
  - fr_data/fr_blank stable while fr_valid && !fr_ready.
  - fr_valid drops the cycle after acceptance unless a new frame loads in the same cycle (back-to-back allowed).
- Back-pressure: while a frame is pending unaccepted, the shadow keeps updating; the newest values win.

Optional Feature:
- Macro: SEG_ERR_CNT_EN.
- Defined: err_cnt increments on each err_pulse and saturates at 8'hFF. Cleared only by reset.
- Undefined: err_cnt tied to 8'h00 and no counter flops exist; err_pulse is unaffected.

Decomposition:
- Shared package seg_pkg:
  - localparams for the 8 patterns and SEG_BLANK=8'h00.
  - FSM state enum {IDLE, SETTLE, CAPTURED}.
  - Function seg_to_code (pattern→{legal,blank,code[2:0]}).
  - Function is_onehot8.
- Sub-module seg_stable_filter: prev registers, change detect, stability counter. Outputs: stable_strobe, gap.

Test Plan:
- Reset-only: hold reset=0 for 3 cycles with inputs toggling → all outputs 0; fr_valid=0 for 10 cycles after release with den_in=0.
- Full frame, STABLE_CYCLES=3: drive digits 0..7 with codes 0..7 (patterns F8,30,92,79,02,A4,99,C0), 4 cycles each, 1 gap cycle between, fr_ready=1 → fr_valid=1 with fr_data=24'hFAC688, fr_blank=0.
- Glitch: seg_in=30 for 2 cycles then 92 for 3 cycles on den_in=8'h04 → digit 2 code=010, no err_pulse.
- Illegal: den_in=8'h05 with seg_in=F8 held 3 cycles → one err_pulse; seg_in=FF on den_in=8'h01 → one err_pulse. Shadow unchanged in both cases; with SEG_ERR_CNT_EN, err_cnt=2.
- Back-pressure: fr_ready=0, complete frame A then frame B → fr_data stays A. Raise fr_ready 1 cycle → next cycle fr_data=B, fr_valid=1.
- Blank and reset mid-frame: seg_in=00 on digit 7 → fr_blank[7]=1 with code 000. Reset asserted after 4 digits → no frame until all 8 are recaptured.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the segment-scan receiver: pattern table, FSM states and
// pattern/enable decode helpers.
package seg_pkg;

    localparam logic [7:0] SEG_CODE0 = 8'hF8;
    localparam logic [7:0] SEG_CODE1 = 8'h30;
    localparam logic [7:0] SEG_CODE2 = 8'h92;
    localparam logic [7:0] SEG_CODE3 = 8'h79;
    localparam logic [7:0] SEG_CODE4 = 8'h02;
    localparam logic [7:0] SEG_CODE5 = 8'hA4;
    localparam logic [7:0] SEG_CODE6 = 8'h99;
    localparam logic [7:0] SEG_CODE7 = 8'hC0;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } seg_state_e;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [2:0] code;
    } seg_dec_t;

    function automatic seg_dec_t seg_to_code(input logic [7:0] pat);
        seg_dec_t dec;
        dec = '{legal: 1'b1, blank: 1'b0, code: 3'd0};
        unique case (pat)
            SEG_CODE0: dec.code = 3'd0;
            SEG_CODE1: dec.code = 3'd1;
            SEG_CODE2: dec.code = 3'd2;
            SEG_CODE3: dec.code = 3'd3;
            SEG_CODE4: dec.code = 3'd4;
            SEG_CODE5: dec.code = 3'd5;
            SEG_CODE6: dec.code = 3'd6;
            SEG_CODE7: dec.code = 3'd7;
            SEG_BLANK: dec.blank = 1'b1;
            default:   dec.legal = 1'b0;
        endcase
        return dec;
    endfunction

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
    endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Change detector and stability counter: strobes once per value that has held
// unchanged for STABLE_CYCLES consecutive cycles while a digit is enabled.
module seg_stable_filter
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seg_in,
    input  logic [7:0] den_in,
    output logic       stable_strobe,
    output logic       gap
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STABLE_CYCLES);

    seg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       prev_seg_q, prev_den_q;
    logic             changed;

    assign gap     = (den_in == 8'h00);
    assign changed = (seg_in != prev_seg_q) || (den_in != prev_den_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stable_strobe = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gap) begin
                    cnt_d = '0;
                end else begin
                    state_d = SETTLE;
                    cnt_d   = CNT_ONE;
                end
            end
            SETTLE: begin
                if (gap) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    cnt_d = CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CAPTURED: begin
                if (gap) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Shared exit so STABLE_CYCLES==1 captures on the very first cycle of a value.
        if (state_d == SETTLE && cnt_d == CNT_LIM) begin
            stable_strobe = 1'b1;
            state_d       = CAPTURED;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prev_seg_q <= 8'h00;
            prev_den_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_seg_q <= seg_in;
            prev_den_q <= den_in;
        end
    end

endmodule

// File: rtl/seg_scan_receiver.sv
// Recovers 3-bit digit codes from a multiplexed segment bus into 8-digit frames.
// Define SEG_ERR_CNT_EN to build the saturating err_cnt counter.
module seg_scan_receiver
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned CNT_W         = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  seg_in,
    input  logic [7:0]  den_in,
    output logic [23:0] fr_data,
    output logic [7:0]  fr_blank,
    output logic        fr_valid,
    input  logic        fr_ready,
    output logic        err_pulse,
    output logic [7:0]  err_cnt
);

    logic        stable_strobe, gap, eval, legal, load;
    seg_dec_t    dec;
    logic [23:0] shadow_code_q, shadow_code_d;
    logic [7:0]  shadow_blank_q, shadow_blank_d;
    logic [7:0]  shadow_valid_q, shadow_valid_d;
    logic [23:0] fr_data_q, fr_data_d;
    logic [7:0]  fr_blank_q, fr_blank_d;
    logic        fr_valid_q, fr_valid_d;
    logic        err_pulse_q, err_pulse_d;

    seg_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_filter (
        .clk          (clk),
        .reset        (reset),
        .seg_in       (seg_in),
        .den_in       (den_in),
        .stable_strobe(stable_strobe),
        .gap          (gap)
    );

    assign dec   = seg_to_code(seg_in);
    assign eval  = stable_strobe && !gap;
    assign legal = is_onehot8(den_in) && dec.legal;
    assign load  = (&shadow_valid_q) && (!fr_valid_q || fr_ready);

    always_comb begin
        shadow_code_d  = shadow_code_q;
        shadow_blank_d = shadow_blank_q;
        shadow_valid_d = shadow_valid_q;
        fr_data_d      = fr_data_q;
        fr_blank_d     = fr_blank_q;
        fr_valid_d     = fr_valid_q;
        err_pulse_d    = eval && !legal;
        if (load) begin
            fr_data_d      = shadow_code_q;
            fr_blank_d     = shadow_blank_q;
            fr_valid_d     = 1'b1;
            shadow_valid_d = 8'h00;
        end else if (fr_ready) begin
            fr_valid_d = 1'b0;
        end
        // Applied after the transfer so a same-cycle capture starts the next frame.
        if (eval && legal) begin
            for (int i = 0; i < 8; i++) begin
                if (den_in[i]) begin
                    shadow_code_d[3*i +: 3] = dec.code;
                    shadow_blank_d[i]       = dec.blank;
                    shadow_valid_d[i]       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_code_q  <= '0;
            shadow_blank_q <= '0;
            shadow_valid_q <= '0;
            fr_data_q      <= '0;
            fr_blank_q     <= '0;
            fr_valid_q     <= 1'b0;
            err_pulse_q    <= 1'b0;
        end else begin
            shadow_code_q  <= shadow_code_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_valid_q <= shadow_valid_d;
            fr_data_q      <= fr_data_d;
            fr_blank_q     <= fr_blank_d;
            fr_valid_q     <= fr_valid_d;
            err_pulse_q    <= err_pulse_d;
        end
    end

`ifdef SEG_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_cnt_q <= 8'h00;
        end else if (err_pulse_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

    assign fr_data   = fr_data_q;
    assign fr_blank  = fr_blank_q;
    assign fr_valid  = fr_valid_q;
    assign err_pulse = err_pulse_q;

endmodule
